// File: rtl/eth_tx_mux_pkg.sv
// Shared types and constants for the Ethernet TX frame multiplexer.
// Holds the FSM state encoding, the length-counter width for the default minimum frame and the pad byte.
package eth_tx_mux_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PAD, GAP} state_t;

  localparam int MIN_LEN_DEF = 60;
  localparam int LEN_W = $clog2(MIN_LEN_DEF + 1);
  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel at or after ptr, wrapping.
module eth_rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_CH);
      if (!any && req[cand]) begin
        any            = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_mux.sv
// N-channel AXI-Stream frame mux for the MAC TX FIFO: frame-atomic round robin, short-frame padding, programmable IFG.
// Define ETH_TX_MUX_STATS_EN to add per-channel good-frame counters and a padded-frame counter.
module eth_tx_frame_mux
  import eth_tx_mux_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int IFG_W   = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [N_CH*8-1:0]                        s_axis_tdata,
  input  logic [N_CH-1:0]                          s_axis_tvalid,
  output logic [N_CH-1:0]                          s_axis_tready,
  input  logic [N_CH-1:0]                          s_axis_tlast,
  input  logic [N_CH-1:0]                          s_axis_tuser,
  output logic [7:0]                               m_axis_tdata,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic                                     m_axis_tlast,
  output logic                                     m_axis_tuser,
  input  logic [IFG_W-1:0]                         ifg_delay,
  input  logic                                     pad_en,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] grant,
  output logic                                     busy
`ifdef ETH_TX_MUX_STATS_EN
  ,
  output logic [N_CH*32-1:0]                       frame_cnt,
  output logic [31:0]                              pad_cnt
`endif
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BC_W  = $clog2(MIN_LEN + 1);

  state_t            state, next_state;
  logic [IDX_W-1:0]  rr_ptr, arb_idx;
  logic [N_CH-1:0]   arb_oh, grant_oh;
  logic              arb_any;
  logic [BC_W-1:0]   byte_cnt;
  logic [IFG_W-1:0]  gap_cnt;
  logic              pad_hold, user_hold;
  logic              out_free, accept, sel_valid, sel_last, sel_user;
  logic [7:0]        sel_data;
  logic              short_frame, pad_final;

  eth_rr_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
    .req       (s_axis_tvalid),
    .ptr       (rr_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign sel_valid     = |(s_axis_tvalid & grant_oh);
  assign sel_last      = |(s_axis_tlast & grant_oh);
  assign sel_user      = |(s_axis_tuser & grant_oh);
  assign sel_data      = s_axis_tdata[{grant, 3'b000} +: 8];
  assign s_axis_tready = grant_oh & {N_CH{(state == DATA) && out_free}};
  assign accept        = (state == DATA) && sel_valid && out_free;
  assign short_frame   = (int'(byte_cnt) + 1) < MIN_LEN;
  assign pad_final     = (int'(byte_cnt) + 1) >= MIN_LEN;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (arb_any) next_state = DATA;
      DATA: if (accept && sel_last) next_state = (pad_hold && short_frame) ? PAD : GAP;
      PAD:  if (out_free && pad_final) next_state = GAP;
      GAP: begin
        // The tlast beat is still in the output register until it handshakes.
        if (m_axis_tvalid) begin
          if (m_axis_tready && ifg_delay == '0) next_state = IDLE;
        end else if (gap_cnt == '0) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      grant         <= '0;
      grant_oh      <= '0;
      rr_ptr        <= '0;
      byte_cnt      <= '0;
      gap_cnt       <= '0;
      pad_hold      <= 1'b0;
      user_hold     <= 1'b0;
    end else begin
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant    <= arb_idx;
            grant_oh <= arb_oh;
            rr_ptr   <= (arb_idx == IDX_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
            byte_cnt <= '0;
            pad_hold <= pad_en;
          end
        end
        DATA: begin
          if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            if (byte_cnt != BC_W'(MIN_LEN)) byte_cnt <= byte_cnt + 1'b1;
            if (sel_last && pad_hold && short_frame) begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
              user_hold    <= sel_user;
            end else begin
              m_axis_tlast <= sel_last;
              m_axis_tuser <= sel_last && sel_user;
            end
          end
        end
        PAD: begin
          if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= PAD_BYTE;
            m_axis_tlast  <= pad_final;
            m_axis_tuser  <= pad_final && user_hold;
            byte_cnt      <= byte_cnt + 1'b1;
          end
        end
        GAP: begin
          if (m_axis_tvalid) begin
            if (m_axis_tready) gap_cnt <= ifg_delay;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ETH_TX_MUX_STATS_EN
  logic padded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      pad_cnt   <= '0;
      padded    <= 1'b0;
    end else begin
      if (state == IDLE) padded <= 1'b0;
      else if (state == PAD) padded <= 1'b1;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        if (!m_axis_tuser) frame_cnt[{grant, 5'b00000} +: 32] <= frame_cnt[{grant, 5'b00000} +: 32] + 32'd1;
        if (padded) pad_cnt <= pad_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
